// File: rtl/approx_mult_engine.sv
// Self-sequenced approximate multiplier: reads operand pairs, normalises them, multiplies the
// top K bits of each (or all W bits in exact mode), denormalises and writes each product out.
module approx_mult_engine #(
    parameter int W    = 16,
    parameter int K    = 8,
    parameter int N    = 8,
    parameter int IA_W = $clog2(2 * N),
    parameter int OA_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              exact,
    output logic              in_rd,
    output logic [IA_W-1:0]   in_addr,
    input  logic [W-1:0]      in_data,
    output logic              out_wr,
    output logic [OA_W-1:0]   out_addr,
    output logic [2*W-1:0]    out_data,
    output logic              busy,
    output logic              done
);

    localparam int SH_W  = $clog2(W);
    localparam int CNT_W = $clog2(2 * W - 1);
    localparam logic [W-1:0] ONES  = '1;
    localparam logic [W-1:0] KMASK = ONES << (W - K);

    typedef enum logic [3:0] {
        IDLE, RD_A, LD_A, RD_B, LD_B, NORM, MULT, DENORM, WRITE, FIN
    } state_t;

    state_t             state_q, state_d;
    logic [OA_W-1:0]    idx_q, idx_d;
    logic               exact_q, exact_d;
    logic [W-1:0]       rega_q, rega_d, regb_q, regb_d;
    logic [SH_W-1:0]    sha_q, sha_d, shb_q, shb_d;
    logic [2*W-1:0]     res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               zero;
    logic [W-1:0]       mask, a_m, b_m;
    logic [2*W-1:0]     prod;
    logic [OA_W:0]      addr_full;

    // Masking the low bits of the normalised operands equals {P, zeros} of the truncated product.
    assign zero = (rega_q == '0) || (regb_q == '0);
    assign mask = exact_q ? ONES : KMASK;
    assign a_m  = rega_q & mask;
    assign b_m  = regb_q & mask;
    assign prod = (2*W)'(a_m) * (2*W)'(b_m);

    assign addr_full = {idx_q, (state_q == RD_B)};
    assign in_addr   = addr_full[IA_W-1:0];
    assign out_addr  = idx_q;
    assign out_data  = res_q;
    assign busy      = (state_q != IDLE) && (state_q != FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            exact_q <= 1'b0;
            rega_q  <= '0;
            regb_q  <= '0;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exact_q <= exact_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exact_d = exact_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        in_rd   = 1'b0;
        out_wr  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exact_d = exact;
                    idx_d   = '0;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                in_rd   = 1'b1;
                state_d = LD_A;
            end
            LD_A: begin
                rega_d  = in_data;
                sha_d   = '0;
                state_d = RD_B;
            end
            RD_B: begin
                in_rd   = 1'b1;
                state_d = LD_B;
            end
            LD_B: begin
                regb_d  = in_data;
                shb_d   = '0;
                state_d = NORM;
            end
            NORM: begin
                if (zero || (rega_q[W-1] && regb_q[W-1])) begin
                    state_d = MULT;
                end else begin
                    // Operands shift in parallel; one already normalised simply waits.
                    if (!rega_q[W-1]) begin
                        rega_d = rega_q << 1;
                        sha_d  = sha_q + SH_W'(1);
                    end
                    if (!regb_q[W-1]) begin
                        regb_d = regb_q << 1;
                        shb_d  = shb_q + SH_W'(1);
                    end
                end
            end
            MULT: begin
                res_d   = zero ? '0 : prod;
                cnt_d   = zero ? '0 : (CNT_W'(sha_q) + CNT_W'(shb_q));
                state_d = DENORM;
            end
            DENORM: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    res_d = res_q >> 1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                out_wr = 1'b1;
                if (idx_q == OA_W'(N - 1)) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + OA_W'(1);
                    state_d = RD_A;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Directed bench for approx_mult_engine: approximate and exact runs over a fixed operand table,
// per-pair cycle counts, handshake behaviour and a mid-run reset abort.
module tb_approx_mult_engine;

    localparam int W    = 16;
    localparam int K    = 8;
    localparam int N    = 8;
    localparam int IA_W = 4;
    localparam int OA_W = 3;

    localparam logic [15:0] OPA [8] = '{16'h0003, 16'h1234, 16'hFFFF, 16'h0000,
                                        16'h8001, 16'h0001, 16'h00FF, 16'h1FFF};
    localparam logic [15:0] OPB [8] = '{16'h0005, 16'h0100, 16'hFFFF, 16'h8001,
                                        16'h0000, 16'h0001, 16'h8000, 16'h0003};
    localparam logic [31:0] EXP_APX [8] = '{32'h0000000F, 32'h00122000, 32'hFE010000, 32'h00000000,
                                            32'h00000000, 32'h00000001, 32'h007F8000, 32'h00005FA0};
    localparam logic [31:0] EXP_EXA [8] = '{32'h0000000F, 32'h00123400, 32'hFFFE0001, 32'h00000000,
                                            32'h00000000, 32'h00000001, 32'h007F8000, 32'h00005FFD};
    localparam int EXP_CYC [8] = '{49, 25, 8, 8, 8, 53, 24, 39};

    logic              clk = 1'b0;
    logic              rst, start, exact;
    logic              in_rd, out_wr, busy, done;
    logic [IA_W-1:0]   in_addr;
    logic [W-1:0]      in_data;
    logic [OA_W-1:0]   out_addr;
    logic [2*W-1:0]    out_data;

    logic [W-1:0]      mem [0:2*N-1];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int nwr = 0, nrd = 0, ndone = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;
    logic [OA_W-1:0] wa [64];
    logic [31:0]     wd [64];
    int              wc [64];
    logic [IA_W-1:0] ra [128];
    int c0, b_wr, b_rd, b_done, gap;

    approx_mult_engine #(.W(W), .K(K), .N(N), .IA_W(IA_W), .OA_W(OA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exact    (exact),
        .in_rd    (in_rd),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_wr   (out_wr),
        .out_addr (out_addr),
        .out_data (out_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_rd) in_data <= mem[in_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and log any DUT activity seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (out_wr) begin
            if (nwr < 64) begin
                wa[nwr] = out_addr;
                wd[nwr] = out_data;
                wc[nwr] = cyc;
            end
            $display("[TB] write addr=%0d data=%h cycle=%0d", out_addr, out_data, cyc);
            nwr++;
        end
        if (in_rd) begin
            if (nrd < 128) ra[nrd] = in_addr;
            nrd++;
        end
        if (done) begin
            ndone++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    endtask

    task automatic start_run(input logic ex);
        exact  = ex;
        start  = 1'b1;
        c0     = cyc;
        b_wr   = nwr;
        b_rd   = nrd;
        b_done = ndone;
        tick();
        start = 1'b0;
        exact = ~ex;   // must have no effect once the run has begun
    endtask

    task automatic wait_done();
        int bud;
        bud = 0;
        gap = 0;
        while (ndone == b_done && bud < 3000) begin
            if (!busy && !done) gap++;
            start = (bud == 30);   // start while busy must be ignored
            tick();
            bud++;
        end
        start = 1'b0;
        repeat (5) tick();
    endtask

    task automatic check_run(input logic ex);
        int p, prev;
        check("write_count", 64'(nwr - b_wr), 64'd8);
        check("read_count", 64'(nrd - b_rd), 64'd16);
        check("done_count", 64'(ndone - b_done), 64'd1);
        check("busy_gap", 64'(gap), 64'd0);
        check("busy_at_done", 64'(done_busy), 64'd0);
        for (int j = 0; j < 16; j++)
            check($sformatf("rd_addr%0d", j), 64'(ra[b_rd + j]), 64'(j));
        for (int i = 0; i < 8; i++) begin
            p    = b_wr + i;
            prev = (i == 0) ? c0 : wc[p - 1];
            check($sformatf("wr_addr%0d", i), 64'(wa[p]), 64'(i));
            check($sformatf("%s_data%0d", ex ? "exact" : "apx", i), 64'(wd[p]),
                  ex ? 64'(EXP_EXA[i]) : 64'(EXP_APX[i]));
            check($sformatf("cycles%0d", i), 64'(wc[p] - prev), 64'(EXP_CYC[i]));
        end
        check("done_timing", 64'(done_cyc - wc[b_wr + 7]), 64'd1);
    endtask

    initial begin
        int bud;
        for (int i = 0; i < N; i++) begin
            mem[2*i]     = OPA[i];
            mem[2*i + 1] = OPB[i];
        end
        rst   = 1'b1;
        start = 1'b0;
        exact = 1'b0;
        repeat (3) tick();
        check("rst_in_rd", 64'(in_rd), 64'd0);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_addr", 64'(in_addr), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        tick();

        start_run(1'b0);
        wait_done();
        check_run(1'b0);

        start_run(1'b1);
        wait_done();
        check_run(1'b1);

        // Abort during the DENORM cycle of pair 3 (a zero pair: DENORM is its 7th cycle).
        start_run(1'b1);
        bud = 0;
        while ((nwr - b_wr) < 3 && bud < 1000) begin
            tick();
            bud++;
        end
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_wr", 64'(out_wr), 64'd0);
        check("abort_in_rd", 64'(in_rd), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_addr", 64'(out_addr), 64'd0);
        check("abort_in_addr", 64'(in_addr), 64'd0);
        repeat (20) tick();
        check("abort_writes", 64'(nwr - b_wr), 64'd3);
        check("abort_no_done", 64'(ndone - b_done), 64'd0);

        start_run(1'b0);
        wait_done();
        check_run(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
